// File: rtl/sub_serial.sv
// Bit-serial LSB-first subtractor: out = a - b (mod 2^WIDTH), one bit per clock.
// Optional SUB_SERIAL_SAT_EN: clamp the result to zero on final borrow (saturating subtract).
module sub_serial #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             borrow_out
);

    // state | meaning
    // IDLE  | waiting for en; out/borrow_out hold the last result
    // SUB   | one bit subtracted per edge, LSB first
    // DONE  | result valid for exactly one cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             borrow;
    logic [CNT_W-1:0] count;

    logic d;
    logic borrow_nxt;

    assign d          = a_reg[0] ^ b_reg[0] ^ borrow;
    assign borrow_nxt = (~a_reg[0] & b_reg[0]) | (~a_reg[0] & borrow) | (b_reg[0] & borrow);

    assign busy = (state == SUB);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            borrow     <= 1'b0;
            count      <= '0;
            out        <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        borrow     <= 1'b0;
                        count      <= '0;
                        out        <= '0;
                        borrow_out <= 1'b0;
                        state      <= SUB;
                    end
                end
                SUB: begin
                    borrow <= borrow_nxt;
                    out    <= {d, out[WIDTH-1:1]};
                    a_reg  <= a_reg >> 1;
                    b_reg  <= b_reg >> 1;
                    count  <= count + CNT_W'(1);
                    // Last bit: capture the freshly computed borrow, not the registered one
                    if (count == CNT_W'(WIDTH - 1)) begin
                        borrow_out <= borrow_nxt;
                        state      <= DONE;
`ifdef SUB_SERIAL_SAT_EN
                        if (borrow_nxt) begin
                            out <= '0;
                        end
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
